reg_file: RTL and testbench
===========================

Name: reg_file

Overview:
- 32-entry by WIDTH-bit register file, two read ports and one write port.
- Sits directly downstream of the 5:32 write-address decoder. Consumes the decoder's one-hot 32-bit write-enable vector, with enable driven by reg_write.
- Feeds operands to the datapath ALU stage.
- Entry 31 is the hardwired zero register (XZR).

Parameters:
- WIDTH, 64, data width of every register and data port.
- ZERO_REG, 1, when 1 entry 31 reads as zero and ignores writes; when 0 entry 31 is an ordinary register.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- reg_write  input  1  write enable for the current cycle.
- write_reg  input  5  destination register index.
- write_data  input  WIDTH  data to store.
- read_reg1  input  5  port-1 source index.
- read_reg2  input  5  port-2 source index.
- read_data1  output  WIDTH  contents of read_reg1.
- read_data2  output  WIDTH  contents of read_reg2.

Behaviour:
- Storage:
  - 32 registers of WIDTH D flip-flops.
  - Each register's write enable is one bit of the decoded one-hot vector for write_reg, gated by reg_write.
  - Each register holds its value when not enabled: a 2:1 mux per bit, feedback vs write_data.
- Reset:
  - The clock is the only timing reference; reset is synchronous and active-high.
  - On a rising clk edge with reset=1, all 32 registers load 0.
  - Reset overrides any concurrent write; that write is lost.
  - A reset asserted mid-stream takes effect at the next edge only. Reads before that edge still show the old contents.
  - After reset, read_data1 = read_data2 = 0 for every address.
- Write:
  - On a rising edge with reset=0 and reg_write=1, register[write_reg] loads write_data.
  - Exactly one register changes; all other 31 keep their values.
  - reg_write=0: no register changes, regardless of write_reg and write_data.
- Zero register (ZERO_REG=1):
  - Writes to index 31 are discarded (enable bit 31 forced 0).
  - Any read of index 31 returns 0 on both ports.
- Read:
  - Combinational (asynchronous): read_data reflects current register contents through a 32:1 mux per bit, with no clock latency.
  - Both ports are independent and may address the same register.
- Read/write collision (same cycle, read_reg == write_reg):
  - No bypass. Read port returns the old value until the edge, then the new value.
  - A write at edge N is visible on read ports in cycle N+1.
- Width rules:
  - No sign extension or truncation; data passes bit-for-bit.
  - Indices are 5-bit unsigned, and all 32 values are legal.
- Timing:
  - Read path = decoder-independent mux tree; write path = decoder + enable + DFF setup.
  - Gate delays on structural primitives are 50 ps per gate, consistent with the decoder.
  - Bench must sample reads at least 1 ns after address change.

Test Plan:
1. Reset: write 64'hDEADBEEF to every register 0..30, assert reset one edge, then read all 32 indices on both ports -> every read 0.
2. Write/read all: for i=0..30 write i*64'h0101010101010101 with reg_write=1, then sweep read_reg1=i, read_reg2=30-i -> each port returns its index times 64'h0101010101010101.
3. Zero register: write 64'hFFFFFFFFFFFFFFFF to index 31 (ZERO_REG=1) -> read_data1 with read_reg1=31 is 0; repeat with ZERO_REG=0 -> returns 64'hFFFFFFFFFFFFFFFF.
4. Write disable: preload X5=64'h1234, then drive write_reg=5, write_data=64'hABCD, reg_write=0 for 3 edges -> X5 still 64'h1234, no other register changed.
5. Collision and reset priority:
   - With X7=64'h1, write 64'h2 to X7 while read_reg1=7 -> read_data1=1 before the edge, 2 after.
   - Write 64'h3 to X7 with reset=1 on the same edge -> X7=0.

Source files
------------

// File: rtl/reg_file.sv
//------------------------------------------------------------------------------
// reg_file
//
// Purpose:
//   32-entry x WIDTH-bit register file with two combinational read ports and
//   one synchronous write port. It sits just after the 5:32 write-address
//   decoder and feeds operands to the ALU stage. When ZERO_REG is 1, entry 31
//   is the hardwired zero register (XZR). It reads as zero and drops writes.
//
// Parameters:
//   WIDTH     data width of every register and data port (default 64)
//   ZERO_REG  1: entry 31 reads 0 and ignores writes; 0: ordinary register
//
// Ports:
//   clk         in   1      clock; all state updates on the rising edge
//   reset       in   1      synchronous, active-high; clears all 32 entries
//   reg_write   in   1      write enable for the current cycle
//   write_reg   in   5      destination register index
//   write_data  in   WIDTH  data to store
//   read_reg1   in   5      port-1 source index
//   read_reg2   in   5      port-2 source index
//   read_data1  out  WIDTH  contents of read_reg1 (combinational)
//   read_data2  out  WIDTH  contents of read_reg2 (combinational)
//------------------------------------------------------------------------------
module reg_file #(
  parameter int WIDTH    = 64,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             reg_write,
  input  logic [4:0]       write_reg,
  input  logic [WIDTH-1:0] write_data,
  input  logic [4:0]       read_reg1,
  input  logic [4:0]       read_reg2,
  output logic [WIDTH-1:0] read_data1,
  output logic [WIDTH-1:0] read_data2
);

  localparam int NumRegs = 32;
  localparam logic [4:0] ZeroIdx = 5'd31;

  // Storage array, one WIDTH-bit register per entry
  logic [WIDTH-1:0] r_regs [NumRegs];

  // Decoded one-hot write address, the gated per-entry enables and the
  // next-state value of each entry
  logic [NumRegs-1:0] w_decoded;
  logic [NumRegs-1:0] w_enable;
  logic [WIDTH-1:0]   w_next [NumRegs];

  // The 5:32 write-address decoder. It produces exactly one hot bit for every
  // index, so all 32 values of write_reg are legal destinations.
  always_comb begin
    w_decoded = '0;
    w_decoded[write_reg] = 1'b1;
  end

  // reg_write gates the one-hot vector as a whole. With reg_write low, no
  // entry sees an enable, whatever write_reg and write_data hold. When the
  // zero register is enabled, its enable bit is forced low, so a write to
  // index 31 is dropped before it reaches storage.
  always_comb begin
    w_enable = reg_write ? w_decoded : '0;
    if (ZERO_REG) begin
      w_enable[ZeroIdx] = 1'b0;
    end
  end

  // One register per entry. Each entry's D input comes from a 2:1 mux that
  // picks between feedback (hold) and write_data. Reset is synchronous and
  // has priority over any write on the same edge, so that write is lost.
  // A reset asserted mid-cycle changes nothing until the edge. Reads before
  // that edge still show the old contents.
  genvar gi;
  generate
    for (gi = 0; gi < NumRegs; gi++) begin : g_entry
      always_comb begin
        w_next[gi] = w_enable[gi] ? write_data : r_regs[gi];
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          r_regs[gi] <= '0;
        end else begin
          r_regs[gi] <= w_next[gi];
        end
      end
    end
  endgenerate

  // Read port 1 is a plain 32:1 mux on the stored contents. There is no
  // write bypass: a same-cycle write to the addressed entry shows up only
  // after the edge. Index 31 is masked to zero when XZR is in use. Entry 31
  // can never be written in that mode, so the mask only matters if someone
  // removes the write-side guard. It keeps the read-side contract explicit.
  always_comb begin
    read_data1 = r_regs[read_reg1];
    if (ZERO_REG && (read_reg1 == ZeroIdx)) begin
      read_data1 = '0;
    end
  end

  // Read port 2 works the same way as port 1 and is fully independent of it.
  // Both ports may address the same entry in the same cycle.
  always_comb begin
    read_data2 = r_regs[read_reg2];
    if (ZERO_REG && (read_reg2 == ZeroIdx)) begin
      read_data2 = '0;
    end
  end

endmodule

// File: tb/tb_reg_file.sv
//------------------------------------------------------------------------------
// tb_reg_file
//
// Purpose:
//   Self-checking bench for reg_file. Two instances share all inputs: one with
//   ZERO_REG=1 and one with ZERO_REG=0. Each instance has a reference array
//   that models the register file as a plain list of 32 values. The bench
//   runs the directed scenarios, then a randomized stream, and compares both
//   read ports of both instances against the models.
//------------------------------------------------------------------------------
module tb_reg_file;

  localparam int W = 64;
  localparam logic [63:0] Step = 64'h0101010101010101;

  logic         clk = 1'b0;
  logic         reset;
  logic         reg_write;
  logic [4:0]   write_reg;
  logic [W-1:0] write_data;
  logic [4:0]   read_reg1;
  logic [4:0]   read_reg2;
  logic [W-1:0] rd1Z, rd2Z, rd1N, rd2N;

  int checks = 0;
  int errors = 0;

  // Reference contents: modelZ for the XZR instance, modelN for the plain one
  logic [W-1:0] modelZ [32];
  logic [W-1:0] modelN [32];

  // 10 ns clock with the first rising edge at 5 ns
  always #5 clk = ~clk;

  reg_file #(.WIDTH(W), .ZERO_REG(1'b1)) uDutZ (
    .clk(clk), .reset(reset), .reg_write(reg_write), .write_reg(write_reg),
    .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(rd1Z), .read_data2(rd2Z)
  );

  reg_file #(.WIDTH(W), .ZERO_REG(1'b0)) uDutN (
    .clk(clk), .reset(reset), .reg_write(reg_write), .write_reg(write_reg),
    .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(rd1N), .read_data2(rd2N)
  );

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [W-1:0] got,
                             input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Expected read value from the architectural rules
  function automatic logic [W-1:0] expZ(input int idx);
    return (idx == 31) ? '0 : modelZ[idx];
  endfunction

  function automatic logic [W-1:0] expN(input int idx);
    return modelN[idx];
  endfunction

  // Apply one clock edge with the given controls and update the models when
  // that edge lands. The controls then drop back to idle, so later reads can
  // span any number of edges without changing state.
  task automatic applyStimulus(input bit rst, input bit we, input logic [4:0] wr,
                               input logic [W-1:0] wd);
    reset      = rst;
    reg_write  = we;
    write_reg  = wr;
    write_data = wd;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        modelZ[i] = '0;
        modelN[i] = '0;
      end
    end else if (we) begin
      modelN[wr] = wd;
      if (wr != 5'd31) modelZ[wr] = wd;
    end
    #1;
    reset     = 1'b0;
    reg_write = 1'b0;
  endtask

  // Drive both read addresses, let the mux settle (more than 1 ns), then
  // check both ports of both instances
  task automatic readCheck(input string tag, input logic [4:0] r1,
                           input logic [4:0] r2);
    read_reg1 = r1;
    read_reg2 = r2;
    #2;
    checkOutput({tag, "_z_p1"}, rd1Z, expZ(int'(r1)));
    checkOutput({tag, "_z_p2"}, rd2Z, expZ(int'(r2)));
    checkOutput({tag, "_n_p1"}, rd1N, expN(int'(r1)));
    checkOutput({tag, "_n_p2"}, rd2N, expN(int'(r2)));
  endtask

  task automatic sweepAll(input string tag);
    for (int i = 0; i < 32; i++) begin
      readCheck(tag, 5'(i), 5'(31 - i));
    end
  endtask

  initial begin
    logic [W-1:0] tmp;
    reset      = 1'b0;
    reg_write  = 1'b0;
    write_reg  = '0;
    write_data = '0;
    read_reg1  = '0;
    read_reg2  = '0;
    for (int i = 0; i < 32; i++) begin
      modelZ[i] = 'x;
      modelN[i] = 'x;
    end
    #1;

    // Power-up reset, then every entry reads zero
    applyStimulus(1'b1, 1'b0, 5'd0, '0);
    sweepAll("por");

    // Fill entries with DEADBEEF, then reset for one edge with a write
    // pending. The reset must win and every entry must read zero.
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 1'b1, 5'(i), 64'hDEADBEEF);
    end
    readCheck("fill", 5'd3, 5'd31);
    applyStimulus(1'b1, 1'b1, 5'd4, 64'h5555);
    sweepAll("rst");

    // Write index*Step to 0..30, then sweep with port 2 reversed
    for (int i = 0; i < 31; i++) begin
      tmp = Step * 64'(i);
      applyStimulus(1'b0, 1'b1, 5'(i), tmp);
    end
    for (int i = 0; i < 31; i++) begin
      readCheck("wr_all", 5'(i), 5'(30 - i));
      checkOutput("wr_all_abs", rd1N, Step * 64'(i));
    end

    // Zero register: XZR instance stays 0, plain instance keeps the value
    applyStimulus(1'b0, 1'b1, 5'd31, 64'hFFFFFFFFFFFFFFFF);
    readCheck("zreg", 5'd31, 5'd31);
    checkOutput("zreg_abs_z", rd1Z, 64'h0);
    checkOutput("zreg_abs_n", rd1N, 64'hFFFFFFFFFFFFFFFF);

    // Write disable: X5 must survive three disabled edges
    applyStimulus(1'b0, 1'b1, 5'd5, 64'h1234);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b0, 5'd5, 64'hABCD);
    end
    readCheck("wdis", 5'd5, 5'd5);
    checkOutput("wdis_abs", rd1Z, 64'h1234);
    sweepAll("wdis_all");

    // Collision: the old value is visible before the edge, the new one after
    applyStimulus(1'b0, 1'b1, 5'd7, 64'h1);
    read_reg1  = 5'd7;
    read_reg2  = 5'd7;
    reg_write  = 1'b1;
    write_reg  = 5'd7;
    write_data = 64'h2;
    #2;
    checkOutput("coll_pre", rd1Z, 64'h1);
    checkOutput("coll_pre_n", rd2N, 64'h1);
    applyStimulus(1'b0, 1'b1, 5'd7, 64'h2);
    #1;
    checkOutput("coll_post", rd1Z, 64'h2);
    checkOutput("coll_post_n", rd2N, 64'h2);

    // Reset mid-stream with a concurrent write. Contents stay old until the
    // edge, and afterwards X7 is 0 because the write is lost.
    reset      = 1'b1;
    reg_write  = 1'b1;
    write_reg  = 5'd7;
    write_data = 64'h3;
    #2;
    checkOutput("rstpri_pre", rd1Z, 64'h2);
    checkOutput("rstpri_pre_o", rd2N, 64'h2);
    applyStimulus(1'b1, 1'b1, 5'd7, 64'h3);
    readCheck("rstpri", 5'd7, 5'd30);
    checkOutput("rstpri_abs", rd1N, 64'h0);

    // Randomized traffic against the models
    for (int n = 0; n < 400; n++) begin
      tmp = {$urandom, $urandom};
      applyStimulus(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                    5'($urandom_range(0, 31)), tmp);
      readCheck("rand", 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end
    sweepAll("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
